// File: rtl/ext_seq_mult_execute_if.sv
// rtl/ext_seq_mult_execute_if.sv - RISC-MGMT execute handshake between RISC-MGMT and the extension
interface ext_seq_mult_execute_if #(
  parameter int WORD_W = 32
);
  logic              start;
  logic [1:0]        op_sel;
  logic [WORD_W-1:0] rdata_s_0;
  logic [WORD_W-1:0] rdata_s_1;
  logic [WORD_W-1:0] pc;
  logic              busy;
  logic              reg_w;
  logic [WORD_W-1:0] reg_wdata;
  logic              exception;
  logic              branch_jump;
  logic [WORD_W-1:0] br_j_addr;

  modport master (
    output start, op_sel, rdata_s_0, rdata_s_1, pc,
    input  busy, reg_w, reg_wdata, exception, branch_jump, br_j_addr
  );

  modport slave (
    input  start, op_sel, rdata_s_0, rdata_s_1, pc,
    output busy, reg_w, reg_wdata, exception, branch_jump, br_j_addr
  );
endinterface

// File: rtl/ext_seq_mult_execute.sv
// rtl/ext_seq_mult_execute.sv - extension execute stage: radix-2 sequential MUL/MULHU and single-cycle BRNZ
module ext_seq_mult_execute #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  ext_seq_mult_execute_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

  state_t                state;
  logic [2*WORD_W-1:0]   product;
  logic [WORD_W-1:0]     mcand;
  logic [WORD_W-1:0]     mplier;
  logic [CNT_W-1:0]      cnt;
  logic                  op_hi;

  logic                  accept;
  logic                  mult_op;
  logic                  brnz_op;
  logic                  ill_op;
  logic                  taken;
  logic [WORD_W:0]       sum;
  logic [WORD_W-1:0]     target;

  // A start seen mid-multiply is dropped entirely, including BRNZ and illegal ops.
  assign accept  = bus.start & (state != MULT) & ~RST;
  assign mult_op = accept & ~bus.op_sel[1];
  assign brnz_op = accept & (bus.op_sel == 2'b10);
  assign ill_op  = accept & (bus.op_sel == 2'b11);

  assign sum    = {1'b0, product[2*WORD_W-1:WORD_W]} + (mplier[0] ? {1'b0, mcand} : '0);
  assign target = bus.pc + bus.rdata_s_1;
  assign taken  = brnz_op & (bus.rdata_s_0 != '0);

  assign bus.busy        = ~RST & ((state == MULT) | mult_op);
  assign bus.reg_w       = (state == DONE);
  assign bus.reg_wdata   = (state != DONE) ? '0 :
                           (op_hi ? product[2*WORD_W-1:WORD_W] : product[WORD_W-1:0]);
  assign bus.branch_jump = taken;
  assign bus.br_j_addr   = taken ? target : '0;
  assign bus.exception   = (taken & (target[1:0] != 2'b00)) | ill_op;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      op_hi   <= 1'b0;
    end else begin
      case (state)
        MULT: begin
          // Add into the upper half, then shift the whole accumulator right by one.
          product <= {sum, product[WORD_W-1:1]};
          mplier  <= mplier >> 1;
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_W'(WORD_W - 1))
            state <= DONE;
        end
        default: begin
          if (mult_op) begin
            mcand   <= bus.rdata_s_0;
            mplier  <= bus.rdata_s_1;
            product <= '0;
            cnt     <= '0;
            op_hi   <= bus.op_sel[0];
            state   <= MULT;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ext_seq_mult_execute.sv
// tb/tb_ext_seq_mult_execute.sv - directed self-checking bench for ext_seq_mult_execute
module tb_ext_seq_mult_execute;
  logic CLK;
  logic RST;
  int   passed;
  int   total;
  logic seen;

  ext_seq_mult_execute_if #(.WORD_W(32)) bus ();

  ext_seq_mult_execute #(.WORD_W(32), .CNT_W(6)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic drive(input logic s, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] p);
    bus.start     = s;
    bus.op_sel    = op;
    bus.rdata_s_0 = a;
    bus.rdata_s_1 = b;
    bus.pc        = p;
    #1;
  endtask

  task automatic tick();
    @(negedge CLK);
    bus.start = 1'b0;
    #1;
  endtask

  // Counts busy cycles from the current (start) cycle and stops in the DONE cycle.
  task automatic finish_mul(input string tag, input logic [31:0] exp, input int pulse_at);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      @(negedge CLK);
      if (n == pulse_at) drive(1'b1, 2'b00, 32'd3, 32'd5, 32'd0);
      else begin bus.start = 1'b0; #1; end
    end
    chk({tag, "_busy_cycles"}, n, 32'd33);
    chk({tag, "_reg_w"}, bus.reg_w, 32'd1);
    chk({tag, "_wdata"}, bus.reg_wdata, exp);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    RST    = 1'b1;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0);
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_busy", bus.busy, 32'd0);
    chk("rst_reg_w", bus.reg_w, 32'd0);
    chk("rst_wdata", bus.reg_wdata, 32'd0);
    chk("rst_exc", bus.exception, 32'd0);
    RST = 1'b0;
    tick();

    // MUL 7*6 with a start pulse mid-multiply, then MULHU back-to-back in DONE
    drive(1'b1, 2'b00, 32'd7, 32'd6, 32'd0);
    finish_mul("mul7x6", 32'd42, 6);
    drive(1'b1, 2'b01, 32'h8000_0000, 32'd4, 32'd0);
    chk("b2b_reg_w", bus.reg_w, 32'd1);
    chk("b2b_wdata", bus.reg_wdata, 32'd42);
    chk("b2b_busy", bus.busy, 32'd1);
    finish_mul("mulhu_b2b", 32'd2, -1);
    tick();
    chk("after_done_reg_w", bus.reg_w, 32'd0);
    chk("after_done_busy", bus.busy, 32'd0);

    drive(1'b1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    finish_mul("mulhu_max", 32'hFFFF_FFFE, -1);
    tick();
    drive(1'b1, 2'b00, 32'h1234_5678, 32'd0, 32'd0);
    finish_mul("mul_zero", 32'd0, -1);
    tick();

    // MUL max, then BRNZ in the DONE cycle
    drive(1'b1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    finish_mul("mul_max", 32'd1, -1);
    drive(1'b1, 2'b10, 32'd1, 32'h20, 32'h100);
    chk("done_brnz_reg_w", bus.reg_w, 32'd1);
    chk("done_brnz_wdata", bus.reg_wdata, 32'd1);
    chk("done_brnz_bj", bus.branch_jump, 32'd1);
    chk("done_brnz_addr", bus.br_j_addr, 32'h120);
    chk("done_brnz_busy", bus.busy, 32'd0);
    tick();
    chk("done_brnz_next_reg_w", bus.reg_w, 32'd0);
    chk("done_brnz_next_bj", bus.branch_jump, 32'd0);

    // BRNZ in IDLE
    drive(1'b1, 2'b10, 32'd1, 32'h20, 32'h100);
    chk("brnz_bj", bus.branch_jump, 32'd1);
    chk("brnz_addr", bus.br_j_addr, 32'h120);
    chk("brnz_exc", bus.exception, 32'd0);
    chk("brnz_busy", bus.busy, 32'd0);
    chk("brnz_reg_w", bus.reg_w, 32'd0);
    drive(1'b1, 2'b10, 32'd0, 32'h20, 32'h100);
    chk("brnz_nt_bj", bus.branch_jump, 32'd0);
    chk("brnz_nt_addr", bus.br_j_addr, 32'd0);
    drive(1'b1, 2'b10, 32'd1, 32'h22, 32'h100);
    chk("brnz_misalign_exc", bus.exception, 32'd1);
    chk("brnz_misalign_addr", bus.br_j_addr, 32'h122);
    drive(1'b1, 2'b10, 32'd5, 32'h20, 32'hFFFF_FFF0);
    chk("brnz_wrap_addr", bus.br_j_addr, 32'h10);
    chk("brnz_wrap_exc", bus.exception, 32'd0);
    tick();
    chk("idle_bj", bus.branch_jump, 32'd0);
    chk("idle_addr", bus.br_j_addr, 32'd0);

    // Illegal op
    drive(1'b1, 2'b11, 32'd1, 32'd2, 32'd3);
    chk("ill_exc", bus.exception, 32'd1);
    chk("ill_busy", bus.busy, 32'd0);
    chk("ill_reg_w", bus.reg_w, 32'd0);
    chk("ill_bj", bus.branch_jump, 32'd0);
    tick();
    chk("ill_next_exc", bus.exception, 32'd0);
    chk("ill_next_busy", bus.busy, 32'd0);
    chk("ill_next_reg_w", bus.reg_w, 32'd0);

    // Reset mid-multiply aborts with no write
    drive(1'b1, 2'b00, 32'd7, 32'd6, 32'd0);
    repeat (10) tick();
    chk("pre_rst_busy", bus.busy, 32'd1);
    RST = 1'b1;
    #1;
    chk("mid_rst_busy", bus.busy, 32'd0);
    chk("mid_rst_reg_w", bus.reg_w, 32'd0);
    chk("mid_rst_wdata", bus.reg_wdata, 32'd0);
    chk("mid_rst_exc", bus.exception, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (bus.reg_w !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
    end
    chk("no_write_after_rst", seen, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
